canvas_grid_reader: RTL and testbench

CANVAS_GRID_READER -- requirements
Module: canvas_grid_reader

---
 rtl/canvas_pkg.sv | 25 ++
 rtl/cell_scan_counter.sv | 49 ++++
 rtl/canvas_grid_reader.sv | 172 +++++++++++++++++
 tb/tb_canvas_grid_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// Shared canvas geometry, draw colour and reader state encoding; also used by
// the drawing writer so both agree on cell layout.
package canvas_pkg;

    localparam logic [14:0] DRAWCOLOUR = 15'h7FFF;
    localparam int          CELL_W     = 10;
    localparam int          CELL_H     = 14;
    localparam int          GRID_W     = 16;
    localparam int          GRID_H     = 8;
    localparam int          X0         = 0;
    localparam int          Y0         = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic pixel_match(input logic [14:0] pix, input logic [14:0] colour);
        return (pix == colour);
    endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// Nested pixel counter within one cell: px runs fastest, py advances on px wrap.
// Exposes the next position so the caller can register addresses without lag.
module cell_scan_counter #(
    parameter int CELL_W = 10,
    parameter int CELL_H = 14
) (
    input  logic       CLOCK,
    input  logic       resetn,
    input  logic       clear,
    input  logic       step,
    output logic [7:0] nxt_px,
    output logic [6:0] nxt_py,
    output logic       last
);

    logic [7:0] px_r;
    logic [6:0] py_r;
    logic       px_end_s;
    logic       py_end_s;

    // Terminal detection and next-position computation.
    always_comb begin
        px_end_s = (px_r == 8'(CELL_W - 1));
        py_end_s = (py_r == 7'(CELL_H - 1));
        last     = px_end_s && py_end_s;
        if (px_end_s) begin
            nxt_px = 8'd0;
            nxt_py = py_end_s ? 7'd0 : (py_r + 7'd1);
        end else begin
            nxt_px = px_r + 8'd1;
            nxt_py = py_r;
        end
    end

    // Position register.
    always_ff @(posedge CLOCK) begin
        if (!resetn) begin
            px_r <= 8'd0;
            py_r <= 7'd0;
        end else if (clear) begin
            px_r <= 8'd0;
            py_r <= 7'd0;
        end else if (step) begin
            px_r <= nxt_px;
            py_r <= nxt_py;
        end
    end

endmodule

// File: rtl/canvas_grid_reader.sv
// Scans the canvas cell by cell and reports, per cell, whether any pixel equals
// the draw colour, using a valid/ready handshake per cell result.
module canvas_grid_reader #(
    parameter logic [14:0] DRAWCOLOUR = canvas_pkg::DRAWCOLOUR,
    parameter int          CELL_W     = canvas_pkg::CELL_W,
    parameter int          CELL_H     = canvas_pkg::CELL_H,
    parameter int          GRID_W     = canvas_pkg::GRID_W,
    parameter int          GRID_H     = canvas_pkg::GRID_H,
    parameter int          X0         = canvas_pkg::X0,
    parameter int          Y0         = canvas_pkg::Y0
) (
    input  logic        CLOCK,
    input  logic        resetn,
    input  logic        start,
    output logic [7:0]  rd_x,
    output logic [6:0]  rd_y,
    input  logic [14:0] rd_data,
    output logic        cell_valid,
    input  logic        cell_ready,
    output logic        cell_bit,
    output logic [6:0]  cell_index,
    output logic        busy,
    output logic        done
);

    import canvas_pkg::state_t;
    import canvas_pkg::ST_IDLE;
    import canvas_pkg::ST_SCAN;
    import canvas_pkg::ST_DRAIN;
    import canvas_pkg::ST_EMIT;
    import canvas_pkg::ST_DONE;
    import canvas_pkg::pixel_match;

    localparam logic [6:0] LAST_INDEX = 7'(GRID_W * GRID_H - 1);

    state_t     state_r;
    logic [7:0] base_x_r;
    logic [6:0] base_y_r;
    logic [6:0] col_r;
    logic       hit_r;
    logic       issue_r;
    logic       data_v_r;

    logic [7:0] nxt_px_s;
    logic [6:0] nxt_py_s;
    logic       pix_last_s;
    logic       sample_hit_s;
    logic       col_end_s;
    logic       last_cell_s;
    logic       transfer_s;
    logic       cnt_clear_s;
    logic       cnt_step_s;
    logic [7:0] nb_x_s;
    logic [6:0] nb_y_s;

    cell_scan_counter #(
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) u_pix (
        .CLOCK  (CLOCK),
        .resetn (resetn),
        .clear  (cnt_clear_s),
        .step   (cnt_step_s),
        .nxt_px (nxt_px_s),
        .nxt_py (nxt_py_s),
        .last   (pix_last_s)
    );

    // data_v_r marks the cycle in which rd_data answers an issued address;
    // next cell bases come from running adders rather than col*CELL_W.
    always_comb begin
        sample_hit_s = data_v_r && pixel_match(rd_data, DRAWCOLOUR);
        col_end_s    = (col_r == 7'(GRID_W - 1));
        last_cell_s  = (cell_index == LAST_INDEX);
        transfer_s   = (state_r == ST_EMIT) && cell_ready;
        cnt_clear_s  = ((state_r == ST_IDLE) && start) || (transfer_s && !last_cell_s);
        cnt_step_s   = (state_r == ST_SCAN) && !pix_last_s;
        if (col_end_s) begin
            nb_x_s = 8'(X0);
            nb_y_s = base_y_r + 7'(CELL_H);
        end else begin
            nb_x_s = base_x_r + 8'(CELL_W);
            nb_y_s = base_y_r;
        end
    end

    // Main sequencer: address issue, hit accumulation, handshake and done.
    always_ff @(posedge CLOCK) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            base_x_r   <= 8'd0;
            base_y_r   <= 7'd0;
            col_r      <= 7'd0;
            hit_r      <= 1'b0;
            issue_r    <= 1'b0;
            data_v_r   <= 1'b0;
            rd_x       <= 8'd0;
            rd_y       <= 7'd0;
            cell_valid <= 1'b0;
            cell_bit   <= 1'b0;
            cell_index <= 7'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_v_r <= issue_r;
            issue_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_SCAN;
                        base_x_r   <= 8'(X0);
                        base_y_r   <= 7'(Y0);
                        col_r      <= 7'd0;
                        cell_index <= 7'd0;
                        hit_r      <= 1'b0;
                        rd_x       <= 8'(X0);
                        rd_y       <= 7'(Y0);
                        issue_r    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    hit_r <= hit_r | sample_hit_s;
                    if (pix_last_s) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        rd_x    <= base_x_r + nxt_px_s;
                        rd_y    <= base_y_r + nxt_py_s;
                        issue_r <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    hit_r      <= hit_r | sample_hit_s;
                    cell_bit   <= hit_r | sample_hit_s;
                    cell_valid <= 1'b1;
                    state_r    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (cell_ready) begin
                        cell_valid <= 1'b0;
                        hit_r      <= 1'b0;
                        if (last_cell_s) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            col_r      <= col_end_s ? 7'd0 : (col_r + 7'd1);
                            base_x_r   <= nb_x_s;
                            base_y_r   <= nb_y_s;
                            rd_x       <= nb_x_s;
                            rd_y       <= nb_y_s;
                            cell_index <= cell_index + 7'd1;
                            issue_r    <= 1'b1;
                            state_r    <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    cell_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_canvas_grid_reader.sv
// Directed bench for canvas_grid_reader with a registered framebuffer model.
module tb_canvas_grid_reader;

    logic        CLOCK = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [14:0] rd_data;
    logic        cell_valid;
    logic        cell_ready;
    logic        cell_bit;
    logic [6:0]  cell_index;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [14:0] fb [0:111][0:159];
    logic        got_bits [0:127];

    canvas_grid_reader dut (
        .CLOCK      (CLOCK),
        .resetn     (resetn),
        .start      (start),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_data    (rd_data),
        .cell_valid (cell_valid),
        .cell_ready (cell_ready),
        .cell_bit   (cell_bit),
        .cell_index (cell_index),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLOCK = ~CLOCK;

    // Framebuffer answers one cycle after the address.
    always @(posedge CLOCK) rd_data <= fb[rd_y][rd_x];

    task automatic fb_clear();
        for (int y = 0; y < 112; y++)
            for (int x = 0; x < 160; x++)
                fb[y][x] = 15'h0000;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        start  = 1'b0;
        repeat (2) @(negedge CLOCK);
        resetn = 1'b1;
    endtask

    task automatic collect(input int pulse_at, output int n, output int order_err,
                           output int done_cnt, output int first_idx, output bit timed_out);
        bit finished;
        n = 0; order_err = 0; done_cnt = 0; first_idx = -1; finished = 1'b0;
        for (int i = 0; i < 128; i++) got_bits[i] = 1'b0;
        cell_ready = 1'b1;
        start = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        for (int c = 0; c < 20000 && !finished; c++) begin
            @(negedge CLOCK);
            start = (c == pulse_at);
            if (cell_valid) begin
                if (n == 0) first_idx = int'(cell_index);
                if (int'(cell_index) != n) order_err++;
                got_bits[cell_index] = cell_bit;
                n++;
            end
            if (done) begin
                done_cnt++;
                finished = 1'b1;
            end
        end
        start = 1'b0;
        timed_out = !finished;
        repeat (5) begin
            @(negedge CLOCK);
            if (done) done_cnt++;
            if (cell_valid) n++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; cell_ready = 1'b0;
        repeat (3) @(negedge CLOCK);
        checks++;
        if ({cell_valid, busy, done, cell_bit} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {cell_valid, busy, done, cell_bit});
        end
        checks++;
        if (cell_index !== 7'd0) begin
            errors++; $display("FAIL reset_index got %0d want 0", cell_index);
        end
        checks++;
        if ({rd_x, rd_y} !== 15'd0) begin
            errors++; $display("FAIL reset_addr got x=%0d y=%0d want 0,0", rd_x, rd_y);
        end
        resetn = 1'b1;
        @(negedge CLOCK);
    endtask

    task automatic test_latency();
        int  cnt;
        bit  seen;
        fb_clear();
        cell_ready = 1'b0;
        start = 1'b1;
        cnt = 0; seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(posedge CLOCK);
            cnt++;
            @(negedge CLOCK);
            start = 1'b0;
            if (cnt == 2) begin
                checks++;
                if (rd_x !== 8'd1 || rd_y !== 7'd0) begin
                    errors++; $display("FAIL addr_px1 got x=%0d y=%0d want 1,0", rd_x, rd_y);
                end
            end
            if (cnt == 11) begin
                checks++;
                if (rd_x !== 8'd0 || rd_y !== 7'd1) begin
                    errors++; $display("FAIL addr_py1 got x=%0d y=%0d want 0,1", rd_x, rd_y);
                end
            end
            if (cell_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || cnt != 142) begin
            errors++; $display("FAIL latency_first got %0d (seen=%0d) want 142", cnt, seen);
        end
        checks++;
        if (busy !== 1'b1 || cell_index !== 7'd0 || cell_bit !== 1'b0) begin
            errors++; $display("FAIL cell0 got busy=%b idx=%0d bit=%b want 1,0,0", busy, cell_index, cell_bit);
        end
        cell_ready = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        cell_ready = 1'b0;
        checks++;
        if (cell_valid !== 1'b0 || cell_index !== 7'd1 || rd_x !== 8'd10 || rd_y !== 7'd0) begin
            errors++; $display("FAIL after_xfer got v=%b idx=%0d x=%0d y=%0d want 0,1,10,0",
                               cell_valid, cell_index, rd_x, rd_y);
        end
        cnt = 0; seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(posedge CLOCK);
            cnt++;
            @(negedge CLOCK);
            if (cell_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || cnt != 141 || cell_index !== 7'd1) begin
            errors++; $display("FAIL latency_next got %0d idx=%0d want 141 idx=1", cnt, cell_index);
        end
        apply_reset();
    endtask

    task automatic test_backpressure();
        bit found;
        fb_clear();
        fb[5][35] = 15'h7FFF;
        cell_ready = 1'b1;
        start = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge CLOCK);
            if (cell_valid && cell_index == 7'd3) begin
                found = 1'b1;
                cell_ready = 1'b0;
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL bp_reach got no cell 3 want cell 3 valid");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK);
            checks++;
            if (cell_valid !== 1'b1 || cell_index !== 7'd3 || cell_bit !== 1'b1 ||
                rd_x !== 8'd39 || rd_y !== 7'd13) begin
                errors++; $display("FAIL bp_hold cyc%0d got v=%b idx=%0d bit=%b x=%0d y=%0d want 1,3,1,39,13",
                                   i, cell_valid, cell_index, cell_bit, rd_x, rd_y);
            end
        end
        cell_ready = 1'b1;
        @(negedge CLOCK);
        cell_ready = 1'b0;
        checks++;
        if (cell_valid !== 1'b0 || cell_index !== 7'd4 || rd_x !== 8'd40 || rd_y !== 7'd0) begin
            errors++; $display("FAIL bp_release got v=%b idx=%0d x=%0d y=%0d want 0,4,40,0",
                               cell_valid, cell_index, rd_x, rd_y);
        end
        apply_reset();
    endtask

    task automatic test_blank_ignore_start();
        int n, oe, dc, fi, ones;
        bit to;
        fb_clear();
        collect(300, n, oe, dc, fi, to);
        ones = 0;
        for (int i = 0; i < 128; i++) if (got_bits[i]) ones++;
        checks++;
        if (to) begin errors++; $display("FAIL blank_timeout got no done want done"); end
        checks++;
        if (n != 128) begin errors++; $display("FAIL blank_count got %0d want 128", n); end
        checks++;
        if (oe != 0) begin errors++; $display("FAIL blank_order got %0d out-of-order want 0", oe); end
        checks++;
        if (ones != 0) begin errors++; $display("FAIL blank_bits got %0d set want 0", ones); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL blank_done got %0d pulses want 1", dc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL blank_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit found;
        int extra;
        fb_clear();
        cell_ready = 1'b1;
        start = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 8000 && !found; c++) begin
            @(negedge CLOCK);
            if (cell_valid && cell_index == 7'd40) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_reach got no cell 40 want cell 40 valid"); end
        resetn = 1'b0;
        @(negedge CLOCK);
        checks++;
        if (cell_valid !== 1'b0 || busy !== 1'b0 || cell_index !== 7'd0) begin
            errors++; $display("FAIL rst_abort got v=%b busy=%b idx=%0d want 0,0,0", cell_valid, busy, cell_index);
        end
        resetn = 1'b1;
        extra = 0;
        repeat (300) begin
            @(negedge CLOCK);
            if (cell_valid || done) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL rst_quiet got %0d active cycles want 0", extra); end
    endtask

    task automatic test_pattern();
        int n, oe, dc, fi, ones;
        bit to;
        fb_clear();
        fb[20][25]  = 15'h7FFF;
        fb[111][159] = 15'h7FFF;
        fb[5][45]   = 15'h7FFE;
        collect(-1, n, oe, dc, fi, to);
        ones = 0;
        for (int i = 0; i < 128; i++) if (got_bits[i]) ones++;
        checks++;
        if (to || n != 128 || oe != 0) begin
            errors++; $display("FAIL pat_stream got n=%0d order_err=%0d timeout=%0d want 128,0,0", n, oe, to);
        end
        checks++;
        if (fi != 0) begin errors++; $display("FAIL pat_first got %0d want 0", fi); end
        checks++;
        if (got_bits[18] !== 1'b1) begin errors++; $display("FAIL pat_cell18 got %b want 1", got_bits[18]); end
        checks++;
        if (got_bits[127] !== 1'b1) begin errors++; $display("FAIL pat_cell127 got %b want 1", got_bits[127]); end
        checks++;
        if (got_bits[4] !== 1'b0) begin errors++; $display("FAIL pat_nearmiss got %b want 0", got_bits[4]); end
        checks++;
        if (ones != 2) begin errors++; $display("FAIL pat_ones got %0d want 2", ones); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL pat_done got %0d pulses want 1", dc); end
    endtask

    initial begin
        fb_clear();
        resetn = 1'b0;
        start = 1'b0;
        cell_ready = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_blank_ignore_start();
        test_reset_mid();
        test_pattern();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
